// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier and controller for SMUL/UMUL.
// One conditional add per RUN cycle, a sign-fix cycle, then a one-cycle
// done/write strobe. Stalls the IP counter while an operation is in flight.
//
// Optional build macro: MUL_EARLY_EXIT_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero, so latency scales with the magnitude of operand B.

module mul_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iOperandA,
    input  logic [WIDTH-1:0] iOperandB,
    output logic             oBusy,
    output logic             oStall,
    output logic             oDone,
    output logic             oWriteEnable,
    output logic [WIDTH-1:0] oResult,
    output logic [WIDTH-1:0] oResultHigh
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e            r_state;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [CntW-1:0]   r_cnt;
    logic              r_neg;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  r_result_high;

    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic              w_neg;
    logic [PW-1:0]     w_acc_next;
    logic [PW-1:0]     w_product;
    logic              w_last;

    // Operand magnitudes and result sign, evaluated on the start request.
    // Negating the most negative value wraps to itself, which read as unsigned
    // is exactly its magnitude.
    always_comb begin
        w_abs_a = (iSigned && iOperandA[WIDTH-1]) ? (-iOperandA) : iOperandA;
        w_abs_b = (iSigned && iOperandB[WIDTH-1]) ? (-iOperandB) : iOperandB;
        w_neg   = iSigned && (iOperandA[WIDTH-1] ^ iOperandB[WIDTH-1]);
    end

    // Datapath: conditional add of the shifted multiplicand, and the final
    // sign-corrected product taken from the accumulator.
    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_product  = r_neg ? (-r_acc) : r_acc;
    end

    // Last RUN cycle detection; early exit stops once no set multiplier bits remain.
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        w_last = (r_cnt == CntLast) || (r_mplier[WIDTH-1:1] == '0);
`else
        w_last = (r_cnt == CntLast);
`endif
    end

    // Sequencer FSM with registered datapath state and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state       <= StIdle;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_neg         <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_result_high <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    // Product registers change only here, so they hold through IDLE.
                    r_result      <= w_product[WIDTH-1:0];
                    r_result_high <= w_product[PW-1:WIDTH];
                    r_done        <= 1'b1;
                    r_state       <= StDone;
                end
                StDone: begin
                    // iStart on this edge is deliberately not accepted.
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Status and strobe outputs; the stall also covers the request cycle in IDLE
    // so the IP does not advance past the multiply opcode.
    always_comb begin
        oBusy        = (r_state != StIdle);
        oStall       = (iStart && (r_state == StIdle)) || (r_state == StRun) ||
                       (r_state == StFix);
        oDone        = r_done;
        oWriteEnable = r_done;
        oResult      = r_result;
        oResultHigh  = r_result_high;
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases followed by
// randomized operands compared against an arithmetic reference product.

module tb_mul_sequencer;

    localparam int unsigned W = 16;

    logic             Clock;
    logic             Reset;
    logic             iStart;
    logic             iSigned;
    logic [W-1:0]     iOperandA;
    logic [W-1:0]     iOperandB;
    logic             oBusy;
    logic             oStall;
    logic             oDone;
    logic             oWriteEnable;
    logic [W-1:0]     oResult;
    logic [W-1:0]     oResultHigh;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int t_start = 0;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
    int exp_lat;

    mul_sequencer #(.WIDTH(W)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iSigned      (iSigned),
        .iOperandA    (iOperandA),
        .iOperandB    (iOperandB),
        .oBusy        (oBusy),
        .oStall       (oStall),
        .oDone        (oDone),
        .oWriteEnable (oWriteEnable),
        .oResult      (oResult),
        .oResultHigh  (oResultHigh)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    // Reference: full-width product from plain integer arithmetic, and the
    // cycle count from start edge to the done cycle.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint pa, pb, p;
        longint mag_b;
        int     nbits;
        logic [2*W-1:0] prod;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        prod   = p[2*W-1:0];
        exp_lo = prod[W-1:0];
        exp_hi = prod[2*W-1:W];
        mag_b  = (pb < 0) ? -pb : pb;
        nbits  = 0;
        while (mag_b != 0) begin
            nbits++;
            mag_b = mag_b >> 1;
        end
`ifdef MUL_EARLY_EXIT_EN
        exp_lat = ((nbits == 0) ? 1 : nbits) + 2;
`else
        exp_lat = W + 2;
`endif
    endtask

    // Present a request in IDLE, take the start edge, then scramble operands.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        model(a, b, s);
        iSigned   = s;
        iOperandA = a;
        iOperandB = b;
        iStart    = 1'b1;
        #1;
        chk("stall_on_request", oStall, 1'b1);
        tick();
        t_start   = cyc;
        iStart    = 1'b0;
        iSigned   = 1'(~s);
        iOperandA = W'($urandom);
        iOperandB = W'($urandom);
    endtask

    // Wait (bounded) for oDone and check latency, product and strobes.
    task automatic finish_op(input string tag);
        logic stall_gap;
        stall_gap = 1'b0;
        while (oDone !== 1'b1 && (cyc - t_start) < 200) begin
            if (oStall !== 1'b1) stall_gap = 1'b1;
            tick();
        end
        chk({tag, "_done"}, oDone, 1'b1);
        chk({tag, "_latency"}, 64'(cyc - t_start + 1), 64'(exp_lat));
        chk({tag, "_lo"}, oResult, exp_lo);
        chk({tag, "_hi"}, oResultHigh, exp_hi);
        chk({tag, "_we"}, oWriteEnable, 1'b1);
        chk({tag, "_stall_gap"}, stall_gap, 1'b0);
        chk({tag, "_stall_done"}, oStall, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        start_op(a, b, s);
        finish_op(tag);
        tick();
        chk({tag, "_done_clr"}, oDone, 1'b0);
        chk({tag, "_idle"}, oBusy, 1'b0);
        chk({tag, "_hold"}, {oResultHigh, oResult}, {exp_hi, exp_lo});
    endtask

    initial begin
        int extra;
        Reset     = 1'b0;
        iStart    = 1'b0;
        iSigned   = 1'b0;
        iOperandA = '0;
        iOperandB = '0;
        repeat (3) tick();
        chk("rst_lo", oResult, 16'h0);
        chk("rst_hi", oResultHigh, 16'h0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_we", oWriteEnable, 1'b0);
        chk("rst_stall", oStall, 1'b0);
        Reset = 1'b1;
        tick();

        // Directed products and corner operands.
        run_op("u3x5", 16'h0003, 16'h0005, 1'b0);
        run_op("s-3x5", 16'hFFFD, 16'h0005, 1'b1);
        run_op("uFFFFsq", 16'hFFFF, 16'hFFFF, 1'b0);
        run_op("s8000sq", 16'h8000, 16'h8000, 1'b1);
        run_op("u7x2", 16'h0007, 16'h0002, 1'b0);
        run_op("u7x0", 16'h0007, 16'h0000, 1'b0);
        run_op("s5x-1", 16'h0005, 16'hFFFF, 1'b1);

        // A second request while running is ignored: one completion only.
        start_op(16'h0003, 16'h0005, 1'b0);
        repeat (4) tick();
        iOperandA = 16'h0009;
        iOperandB = 16'h0009;
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        finish_op("ignore");
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (oDone === 1'b1) extra++;
        end
        chk("ignore_extra_done", 64'(extra), 64'd0);
        chk("ignore_lo", oResult, 16'h000F);

        // Asynchronous reset in the middle of RUN aborts everything at once.
        run_op("pre_abort", 16'h0123, 16'h0011, 1'b0);
        start_op(16'h0003, 16'h0005, 1'b0);
        repeat (6) tick();
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_lo", oResult, 16'h0);
        chk("abort_hi", oResultHigh, 16'h0);
        chk("abort_busy", oBusy, 1'b0);
        chk("abort_done", oDone, 1'b0);
        chk("abort_we", oWriteEnable, 1'b0);
        tick();
        #2;
        Reset = 1'b1;
        tick();
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            if (oDone === 1'b1 || oBusy === 1'b1) extra++;
            tick();
        end
        chk("abort_no_activity", 64'(extra), 64'd0);
        run_op("post_abort", 16'h0002, 16'h0002, 1'b0);

        // A request held across DONE->IDLE is taken one edge later.
        start_op(16'h0004, 16'h0006, 1'b0);
        finish_op("b2b_first");
        iOperandA = 16'h0011;
        iOperandB = 16'h0003;
        iSigned   = 1'b0;
        iStart    = 1'b1;
        tick();
        chk("b2b_not_taken", oBusy, 1'b0);
        start_op(16'h0011, 16'h0003, 1'b0);
        chk("b2b_taken", oBusy, 1'b1);
        finish_op("b2b_second");
        tick();

        // Randomized operands, with occasional corner values mixed in.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 5))
                0: a = 16'h8000;
                1: b = W'($urandom_range(0, 3));
                2: b = 16'hFFFF;
                default: ;
            endcase
            run_op("rand", a, b, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
